// File: rtl/pucch_pkg.sv
// Shared definitions for the PUCCH format 0/1 cyclic-shift sequencer:
// FSM state encoding, resource-grid constants and configuration field widths.
package pucch_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Subcarriers per resource block and symbols per slot.
  localparam int N_SC_RB = 12;
  localparam int MAX_SYM = 14;

  // Configuration field widths.
  localparam int M_W       = 4;  // m0, m_cs, m_int
  localparam int NCS_W_DEF = 8;  // default n_cs width
  localparam int SYM_W     = 4;  // start symbol, symbol count
  localparam int IDX_W     = 5;  // subcarrier / symbol index outputs

  // Last subcarrier index within a resource block.
  localparam logic [IDX_W-1:0] LAST_N = IDX_W'(N_SC_RB - 1);

  // A symbol count of zero is treated as a single symbol.
  function automatic logic [SYM_W-1:0] clamp_nsym(input logic [SYM_W-1:0] nsym);
    return (nsym == '0) ? SYM_W'(1) : nsym;
  endfunction

endpackage

// File: rtl/pucch_cs_sequencer_cyclic_shift.sv
// cyclic_shift: phase contribution 2*((sum*n) mod 12) for one subcarrier.
// Purely combinational; the caller supplies registered operands.
module cyclic_shift
  import pucch_pkg::*;
#(
  parameter int SUM_W = 16
) (
  input  logic [SUM_W-1:0] i_sum,
  input  logic [4:0]       i_n,
  output logic [15:0]      o_cyc_part_24
);

  localparam int PW = SUM_W + 5;

  logic [PW-1:0] prod;
  logic [3:0]    rem;

  // Full-width product, reduce modulo 12, then double.
  always_comb begin
    prod          = PW'(i_sum) * PW'(i_n);
    rem           = 4'(prod % PW'(N_SC_RB));
    o_cyc_part_24 = {11'd0, rem, 1'b0};
  end

endmodule

// File: rtl/pucch_cs_sequencer.sv
// pucch_cs_sequencer: walks the configured PUCCH symbols of a slot, fetches
// n_cs per symbol over a req/valid handshake, and streams 12 subcarrier beats
// per symbol (parameter sum, n, phase index) with valid/ready backpressure.
// Optional build macro: PUCCH_CS_SEQ_ABORT_EN adds an i_abort input that
// returns any active sequence to IDLE without an o_done pulse.
module pucch_cs_sequencer
  import pucch_pkg::*;
#(
  parameter int NCS_W = NCS_W_DEF,
  parameter int SUM_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
`ifdef PUCCH_CS_SEQ_ABORT_EN
  input  logic              i_abort,
`endif
  input  logic [3:0]        i_m0,
  input  logic [3:0]        i_mcs,
  input  logic [3:0]        i_mint,
  input  logic [3:0]        i_start_sym,
  input  logic [3:0]        i_nsym,
  output logic              o_ncs_req,
  output logic [4:0]        o_ncs_sym,
  input  logic              i_ncs_valid,
  input  logic [NCS_W-1:0]  i_ncs,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [SUM_W-1:0]  o_sum_params,
  output logic [4:0]        o_n,
  output logic [4:0]        o_sym,
  output logic              o_last_n,
  output logic              o_last,
  output logic [15:0]       o_cyc_part_24,
  output logic              o_busy,
  output logic              o_done
);

  // FSM state and latched configuration.
  state_e             state_q, state_d;
  logic [M_W-1:0]     m0_q, m0_d;
  logic [M_W-1:0]     mcs_q, mcs_d;
  logic [M_W-1:0]     mint_q, mint_d;
  logic [SYM_W-1:0]   start_sym_q, start_sym_d;
  logic [SYM_W-1:0]   nsym_q, nsym_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;

  // Beat fields and registered handshake/status outputs.
  logic [IDX_W-1:0]   ncs_sym_q, ncs_sym_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   sym_q, sym_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               abort_hit;
  logic               more_syms;
  logic               last_sym;
  logic [SUM_W-1:0]   sum_fetch;

`ifdef PUCCH_CS_SEQ_ABORT_EN
  // Abort only acts on an active sequence; in IDLE a start takes priority.
  assign abort_hit = i_abort & (state_q != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Another symbol follows the current one; the current one is the final one.
  assign more_syms = (sym_cnt_q + SYM_W'(1)) < nsym_q;
  assign last_sym  = (sym_cnt_q + SYM_W'(1)) == nsym_q;

  // Parameter sum m0 + m_cs + m_int + n_cs, zero-extended to SUM_W.
  assign sum_fetch = SUM_W'(m0_q) + SUM_W'(mcs_q) + SUM_W'(mint_q) + SUM_W'(i_ncs);

  // Next-state and next-output logic for the IDLE/FETCH/EMIT/DONE walk.
  always_comb begin
    // NOTE: every *_d gets a default here so no path through the case leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    m0_d        = m0_q;
    mcs_d       = mcs_q;
    mint_d      = mint_q;
    start_sym_d = start_sym_q;
    nsym_d      = nsym_q;
    sym_cnt_d   = sym_cnt_q;
    ncs_sym_d   = ncs_sym_q;
    sum_d       = sum_q;
    n_d         = n_q;
    sym_d       = sym_q;
    req_d       = 1'b0;
    valid_d     = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          m0_d        = i_m0;
          mcs_d       = i_mcs;
          mint_d      = i_mint;
          start_sym_d = i_start_sym;
          nsym_d      = clamp_nsym(i_nsym);
          sym_cnt_d   = '0;
          ncs_sym_d   = IDX_W'(i_start_sym);
          req_d       = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      ST_FETCH: begin
        req_d = 1'b1;
        if (i_ncs_valid) begin
          sum_d   = sum_fetch;
          n_d     = '0;
          sym_d   = ncs_sym_q;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        valid_d = 1'b1;
        if (i_ready) begin
          if (n_q != LAST_N) begin
            n_d = n_q + IDX_W'(1);
          end else if (more_syms) begin
            sym_cnt_d = sym_cnt_q + SYM_W'(1);
            ncs_sym_d = IDX_W'(start_sym_q) + IDX_W'(sym_cnt_q) + IDX_W'(1);
            valid_d   = 1'b0;
            req_d     = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_hit) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, configuration and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the data registers are reset as well as the control ones because
      // every output, including the beat fields, must read 0 after reset.
      state_q     <= ST_IDLE;
      m0_q        <= '0;
      mcs_q       <= '0;
      mint_q      <= '0;
      start_sym_q <= '0;
      nsym_q      <= '0;
      sym_cnt_q   <= '0;
      ncs_sym_q   <= '0;
      sum_q       <= '0;
      n_q         <= '0;
      sym_q       <= '0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q     <= state_d;
      m0_q        <= m0_d;
      mcs_q       <= mcs_d;
      mint_q      <= mint_d;
      start_sym_q <= start_sym_d;
      nsym_q      <= nsym_d;
      sym_cnt_q   <= sym_cnt_d;
      ncs_sym_q   <= ncs_sym_d;
      sum_q       <= sum_d;
      n_q         <= n_d;
      sym_q       <= sym_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Phase index from the registered sum and subcarrier index.
  cyclic_shift #(
    .SUM_W (SUM_W)
  ) u_cyclic_shift (
    .i_sum         (sum_q),
    .i_n           (n_q),
    .o_cyc_part_24 (o_cyc_part_24)
  );

  assign o_ncs_req    = req_q;
  assign o_ncs_sym    = ncs_sym_q;
  assign o_valid      = valid_q;
  assign o_sum_params = sum_q;
  assign o_n          = n_q;
  assign o_sym        = sym_q;
  assign o_last_n     = valid_q & (n_q == LAST_N);
  assign o_last       = valid_q & (n_q == LAST_N) & last_sym;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: doc/pucch_cs_sequencer.md
# pucch_cs_sequencer

Sequencer for PUCCH format 0/1 cyclic-shift generation across a slot. On a start pulse it walks the configured symbols; per symbol it fetches n_cs(n_s,f, l+l') from the PRN/gold-sequence block over a request/response handshake. It then streams 12 beats, one per subcarrier index n = 0..11, each carrying the parameter sum, n, and the resulting phase index from the shared `cyclic_shift` datapath. It sits between the slot-level PUCCH configuration and the base-sequence rotator, with valid/ready backpressure toward the rotator.

## Interface
- Parameters:
- `NCS_W`, 8: width of the n_cs input.
- `SUM_W`, 16: width of `o_sum_params`; must match `cyclic_shift` input width.
- Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_start`  in  1  one-cycle start pulse; sampled only in IDLE.
- `i_m0`  in  4  m_0, 0..11.
- `i_mcs`  in  4  m_cs, 0..11.
- `i_mint`  in  4  m_int, 0..11.
- `i_start_sym`  in  4  first symbol l' + l, 0..13.
- `i_nsym`  in  4  number of symbols, 1..14; a value of 0 is treated as 1.
- `o_ncs_req`  out  1  n_cs request, held until response.
- `o_ncs_sym`  out  5  symbol index for request = start_sym + symbol count; no wrap.
- `i_ncs_valid`  in  1  n_cs response strobe.
- `i_ncs`  in  NCS_W  n_cs value.
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream ready.
- `o_sum_params`  out  SUM_W  m0 + mcs + mint + n_cs, zero-extended.
- `o_n`  out  5  subcarrier index 0..11.
- `o_sym`  out  5  current symbol index.
- `o_last_n`  out  1  beat has n = 11.
- `o_last`  out  1  beat has n = 11 on the final symbol.
- `o_cyc_part_24`  out  16  2·((sum·n) mod 12); combinational from the registered sum and n.
- `o_busy`  out  1  high in any state except IDLE.
- `o_done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- FSM states: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - On `i_start`, latch the configuration, clear the symbol count, and go to FETCH.
  - `i_start` is ignored in every other state.
- FETCH:
  - `o_ncs_req` = 1 and `o_ncs_sym` is stable.
  - On `i_ncs_valid`, register the sum and set n = 0, then go to EMIT.
  - `i_ncs_valid` outside FETCH is ignored.
- EMIT:
  - `o_valid` = 1. A beat transfers when `o_valid & i_ready`; fields stay stable while stalled.
  - On transfer with n < 11: n increments.
  - On transfer with n = 11 and more symbols remaining: symbol count increments, go to FETCH.
  - On transfer with n = 11 on the final symbol: go to DONE.
- DONE: `o_done` = 1 for one cycle, then go to IDLE.
- Arithmetic:
  - Sum has at most 3·11 + 255 = 288, which fits in 9 bits; zero-extend to SUM_W.
  - The product sum·n and the mod are computed by `cyclic_shift`.
- Reset mid-operation: return to IDLE in the next cycle. Any outstanding n_cs response is discarded.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including `o_ncs_sym`, `o_sum_params`, `o_n`, `o_sym`, and `o_cyc_part_24`.
- Start to request: `i_start` at cycle T → `o_ncs_req` = 1 at T+1.
- Response to output: `i_ncs_valid` at cycle R → `o_valid` = 1 with n = 0 at R+1.
- Throughput: one beat per cycle while `i_ready` = 1.
- Symbol gap: minimum 2 cycles between the n = 11 transfer and the next n = 0 beat (one FETCH cycle with a same-cycle response).
- `o_done` is asserted in the cycle after the final transfer. `i_start` is accepted again in the cycle after DONE.

## Configuration
- `PUCCH_CS_SEQ_ABORT_EN`:
- Defined: adds an input port `i_abort` (1 bit).
  - Any state except IDLE: the next state is IDLE, and `o_done` is not pulsed.
  - `i_abort` and `i_start` together in IDLE: start wins.
  - `i_abort` and a beat transfer in the same cycle: abort wins.
- Undefined: the port is absent; only reset terminates a sequence.

## Structure
- Shared package `pucch_pkg`:
  - State enum.
  - `N_SC_RB` = 12.
  - `MAX_SYM` = 14.
  - Field widths for m0/mcs/mint/ncs.
- One sub-module: instantiate the existing `cyclic_shift` to produce `o_cyc_part_24` from `o_sum_params` and `o_n`. No other hierarchy.

## Test plan
- m0=3, mcs=6, mint=0, start_sym=0, nsym=1, ncs=5, `i_ready` always 1:
  - 12 beats with sum = 14.
  - Phases: n=1 → 4, n=5 → 20, n=11 → 20.
  - `o_done` at the final transfer cycle + 1.
- nsym=3, start_sym=10, responses after 3 cycles each:
  - Requests for symbols 10, 11, 12.
  - 36 beats total; `o_last` only on the 36th.
- `i_ready` toggled every other cycle: every n value appears exactly once, and fields stay stable during stalls.
- `i_start` re-pulsed during EMIT and `i_ncs_valid` pulsed in IDLE: no effect on state or outputs.
- `i_rst` asserted mid-EMIT at n=6: all outputs 0 in the next cycle. A new start then runs a clean sequence from n=0.
- With `PUCCH_CS_SEQ_ABORT_EN` defined, `i_abort` during FETCH: IDLE next cycle, no `o_done`, `o_ncs_req` deasserted.
